serial_subtractor: RTL and testbench

- Bit-serial, LSB-first N-bit unsigned subtractor that computes diff = a − b over WIDTH clock cycles.
- It sits directly around the half-subtractor cell:
  - the datapath core is one full-subtractor slice, built from two half-subtractor cells plus an OR;
  - a registered borrow is fed back each cycle.
- It trades area for latency and is used wherever wide subtraction is infrequent.
- Operand accept and result delivery both use valid/ready handshakes.

---
 rtl/serial_sub_pkg.sv | 15 +
 rtl/serial_subtractor_if.sv | 35 +++
 rtl/serial_subtractor_full_subtractor.sv | 25 ++
 rtl/serial_subtractor.sv | 142 ++++++++++++++
 tb/tb_serial_subtractor.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_e;

   // Bit-position counter width; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/result handshake bundle for serial_subtractor; ovf exists only with SERIAL_SUB_SIGNED_OVF_EN.
interface serial_subtractor_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start_valid;
   logic             start_ready;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
   logic             busy;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
   logic             ovf;

   modport master (
      output start_valid, a_in, b_in, res_ready,
      input  start_ready, res_valid, diff, borrow_out, busy, ovf
   );
   modport slave (
      input  start_valid, a_in, b_in, res_ready,
      output start_ready, res_valid, diff, borrow_out, busy, ovf
   );
`else
   modport master (
      output start_valid, a_in, b_in, res_ready,
      input  start_ready, res_valid, diff, borrow_out, busy
   );
   modport slave (
      input  start_valid, a_in, b_in, res_ready,
      output start_ready, res_valid, diff, borrow_out, busy
   );
`endif
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor slice built from two half-subtractor cells and an OR.
module half_subtractor (
   input  logic x,
   input  logic y,
   output logic d,
   output logic b
);
   assign d = x ^ y;
   assign b = ~x & y;
endmodule

module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bo
);
   logic d1, b1, b2;

   half_subtractor u_hs0 (.x(x),  .y(y),   .d(d1), .b(b1));
   half_subtractor u_hs1 (.x(d1), .y(bin), .d(d),  .b(b2));

   assign bo = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// LSB-first bit-serial unsigned subtractor, diff = a - b over WIDTH cycles.
// Define SERIAL_SUB_SIGNED_OVF_EN to add the registered two's-complement ovf output.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   serial_subtractor_if.slave  bus
);
   localparam int unsigned CW = cnt_width(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] d_sh_q, d_sh_d;
   logic             brw_q, brw_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;
   logic             rv_q, rv_d;

   logic             s_d, s_bo;
   logic [WIDTH-1:0] d_next;

   full_subtractor u_slice (
      .x   (a_sh_q[0]),
      .y   (b_sh_q[0]),
      .bin (brw_q),
      .d   (s_d),
      .bo  (s_bo)
   );

   assign d_next = {s_d, d_sh_q[WIDTH-1:1]};

`ifdef SERIAL_SUB_SIGNED_OVF_EN
   logic a_msb_q, a_msb_d;
   logic b_msb_q, b_msb_d;
   logic ovf_q, ovf_d;
`endif

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      d_sh_d  = d_sh_q;
      brw_d   = brw_q;
      cnt_d   = cnt_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      rv_d    = rv_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      ovf_d   = ovf_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.start_valid) begin
               a_sh_d  = bus.a_in;
               b_sh_d  = bus.b_in;
               brw_d   = 1'b0;
               cnt_d   = '0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
               a_msb_d = bus.a_in[WIDTH-1];
               b_msb_d = bus.b_in[WIDTH-1];
`endif
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            d_sh_d = d_next;
            brw_d  = s_bo;
            cnt_d  = cnt_q + 1'b1;
            // Last bit: the slice output is the result MSB, so publish straight from it.
            if (cnt_q == CW'(WIDTH - 1)) begin
               diff_d  = d_next;
               bout_d  = s_bo;
               rv_d    = 1'b1;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
               ovf_d   = (a_msb_q != b_msb_q) && (s_d != a_msb_q);
`endif
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.res_ready) begin
               rv_d    = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         d_sh_q  <= '0;
         brw_q   <= 1'b0;
         cnt_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         rv_q    <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         d_sh_q  <= d_sh_d;
         brw_q   <= brw_d;
         cnt_q   <= cnt_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         rv_q    <= rv_d;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign bus.start_ready = (state_q == IDLE);
   assign bus.busy        = (state_q == SHIFT) || (state_q == DONE);
   assign bus.res_valid   = rv_q;
   assign bus.diff        = diff_q;
   assign bus.borrow_out  = bout_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
   assign bus.ovf         = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8) with directed, hand-computed vectors.
module tb_serial_subtractor;
   localparam int unsigned W = 8;

   typedef struct packed {
      logic [7:0] d;
      logic       bo;
      logic       ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_pass  = 0;
   int   n_total = 0;
   exp_t sb[$];

   serial_subtractor_if #(.WIDTH(W)) bus ();

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Monitor: compares every accepted result against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && bus.res_valid && bus.res_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_result", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("diff", 32'(bus.diff), 32'(e.d));
               check("borrow_out", 32'(bus.borrow_out), 32'(e.bo));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
               check("ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
            end
         end
      end
   end

   task automatic wait_idle();
      int cyc = 0;
      while (!bus.start_ready && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("start_ready_timeout", 32'(bus.start_ready), 32'd1);
   endtask

   task automatic start(input logic [7:0] a, input logic [7:0] b);
      bus.a_in        = a;
      bus.b_in        = b;
      bus.start_valid = 1'b1;
      @(posedge clk); #1;
      bus.start_valid = 1'b0;
      bus.a_in        = 8'hA5;
      bus.b_in        = 8'h5A;
   endtask

   task automatic release_result();
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      check("res_valid_cleared", 32'(bus.res_valid), 32'd0);
      check("busy_after_done", 32'(bus.busy), 32'd0);
   endtask

   task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] ed, input logic ebo, input logic eovf);
      exp_t e;
      int   cyc;
      wait_idle();
      e.d = ed; e.bo = ebo; e.ovf = eovf;
      sb.push_back(e);
      start(a, b);
      cyc = 0;
      while (!bus.res_valid && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("latency", 32'(cyc), 32'(W));
      release_result();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      rst_n           = 1'b0;
      bus.start_valid = 1'b0;
      bus.a_in        = '0;
      bus.b_in        = '0;
      bus.res_ready   = 1'b0;
      #2;
      check("rst_res_valid", 32'(bus.res_valid), 32'd0);
      check("rst_diff", 32'(bus.diff), 32'd0);
      check("rst_borrow", 32'(bus.borrow_out), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_start_ready", 32'(bus.start_ready), 32'd1);
      bus.start_valid = 1'b1;
      @(posedge clk); #1;
      bus.start_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("no_load_in_reset", 32'(bus.busy), 32'd0);

      run_op(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
      run_op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
      run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
      run_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);

      // Backpressure with ignored start pulses in SHIFT and DONE.
      wait_idle();
      e.d = 8'hDE; e.bo = 1'b1; e.ovf = 1'b0;
      sb.push_back(e);
      start(8'h11, 8'h33);
      for (int k = 1; k < W; k++) begin
         if (k == 3) begin
            bus.a_in = 8'hFF; bus.b_in = 8'h00; bus.start_valid = 1'b1;
            check("shift_start_ready", 32'(bus.start_ready), 32'd0);
            check("shift_busy", 32'(bus.busy), 32'd1);
         end else begin
            bus.start_valid = 1'b0;
         end
         @(posedge clk); #1;
      end
      bus.start_valid = 1'b0;
      @(posedge clk); #1;
      check("bp_res_valid_at_W", 32'(bus.res_valid), 32'd1);
      for (int h = 0; h < 5; h++) begin
         bus.start_valid = (h % 2 == 0);
         bus.a_in = 8'h00; bus.b_in = 8'hFF;
         check("bp_hold_valid", 32'(bus.res_valid), 32'd1);
         check("bp_hold_diff", 32'(bus.diff), 32'hDE);
         check("bp_hold_borrow", 32'(bus.borrow_out), 32'd1);
         check("bp_start_ready", 32'(bus.start_ready), 32'd0);
         @(posedge clk); #1;
      end
      bus.start_valid = 1'b0;
      release_result();
      check("bp_no_new_load", 32'(bus.start_ready), 32'd1);

      // Asynchronous reset in the middle of SHIFT.
      wait_idle();
      start(8'h5A, 8'h23);
      repeat (4) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_res_valid", 32'(bus.res_valid), 32'd0);
      check("arst_diff", 32'(bus.diff), 32'd0);
      check("arst_borrow", 32'(bus.borrow_out), 32'd0);
      check("arst_busy", 32'(bus.busy), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_op(8'h09, 8'h04, 8'h05, 1'b0, 1'b0);

      run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
      run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
      run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
